// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// seq_divider_pkg : shared state encodings and default width  | Rev 1.0
// ============================================================================
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : seq_divider_pkg
`default_nettype wire

// File: rtl/seq_divider_sub.sv
`default_nettype none
// ============================================================================
// div_sub_stage : ripple full-adder subtract stage, a + (b ^ ctrl) + ctrl  | Rev 1.0
// ============================================================================
module div_sub_stage #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0] a_i,
    input  logic [WIDTH:0] b_i,
    input  logic           ctrl_i,
    output logic [WIDTH:0] diff_o,
    output logic           cout_o
);

    logic [WIDTH+1:0] w_carry;
    logic [WIDTH:0]   w_bx;

    assign w_carry[0] = ctrl_i;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign w_bx[i]        = b_i[i] ^ ctrl_i;
        assign diff_o[i]      = a_i[i] ^ w_bx[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a_i[i] & w_bx[i]) | (w_carry[i] & (a_i[i] ^ w_bx[i]));
    end

    // Carry-out high means the subtraction did not borrow.
    assign cout_o = w_carry[WIDTH + 1];

endmodule : div_sub_stage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// seq_divider : sequential restoring unsigned divider, one quotient bit/clock  | Rev 1.0
// ============================================================================
import seq_divider_pkg::*;

module seq_divider #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [2*WIDTH:0] w_aq_shift;
    logic [WIDTH:0]   w_a_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_no_borrow;
    logic [WIDTH:0]   a_d;
    logic [WIDTH-1:0] q_d;

    assign w_aq_shift = {a_q, q_q} << 1;
    assign w_a_shift  = w_aq_shift[2*WIDTH:WIDTH];

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .a_i    (w_a_shift),
        .b_i    ({1'b0, d_q}),
        .ctrl_i (1'b1),
        .diff_o (w_diff),
        .cout_o (w_no_borrow)
    );

    // Restore by keeping the shifted value whenever the trial subtract borrowed.
    assign a_d = w_no_borrow ? w_diff : w_a_shift;
    assign q_d = w_aq_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, w_no_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        if (divisor_i != '0) begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                            a_q     <= '0;
                            q_q     <= dividend_i;
                            d_q     <= divisor_i;
                            cnt_q   <= CW'(WIDTH - 1);
                            dbz_q   <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quo_q   <= '1;
                            rem_q   <= dividend_i;
                            dbz_q   <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    a_q <= a_d;
                    q_q <= q_d;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quo_q   <= q_d;
                        rem_q   <= a_d[WIDTH-1:0];
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule : seq_divider
`default_nettype wire
